fsm_input_conditioner: RTL
==========================

# fsm_input_conditioner

Front-end stage that cleans the four raw user inputs (i1..i4) before they reach the sequence-detector FSM. Each raw input is synchronised through a two-flop chain and debounced by a per-bit stability counter, producing glitch-free registered levels. The block also emits a one-cycle change strobe and a saturating change-event count for the FSM and for debug. Its outputs i1..i4 connect directly to the FSM's i1..i4 inputs.

## Interface
- DB_CYCLES, 8: consecutive disagreeing cycles required before a clean bit flips; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of each per-bit debounce counter.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- raw_i1, raw_i2, raw_i3, raw_i4  input  1 each  asynchronous raw inputs.
- i1, i2, i3, i4  output  1 each  registered, debounced levels for the FSM.
- chg  output  1  one-cycle pulse, high in the first cycle any of i1..i4 shows a new value.
- evt_cnt  output  8  count of chg pulses since reset; saturates at 255.

## Operation
- Sync chain per bit: s1 <= raw; s2 <= s1. s2 is the only value debounce logic may read.
- Per-bit debounce, two states:
  - STABLE (cnt == 0, s2 == clean): hold.
  - PENDING (s2 != clean): each edge with s2 != clean increments cnt. On the edge where cnt would reach DB_CYCLES, clean <= s2 and cnt <= 0.
  - Any edge with s2 == clean while PENDING: cnt <= 0, clean unchanged (glitch rejected).
- Bits are fully independent; each has its own counter.
- chg <= 1 on the edge where at least one clean bit changes; otherwise 0. Simultaneous flips of several bits give a single pulse. Flips on different edges give separate pulses.
- evt_cnt increments on every edge that asserts chg. It holds at 255 and never wraps.
- Reset (reset == 0 at an edge): s1, s2, clean bits, all cnt, chg, and evt_cnt go to 0. An in-progress count is discarded. Reset has priority over every other update.
- Reset values of outputs: i1..i4 = 0, chg = 0, evt_cnt = 0.

## Timing
- If a raw bit changes and holds from before edge k: s2 updates at edge k+1. The clean output and chg update at edge k+1+DB_CYCLES. With the default, that is edge k+9.
- A raw pulse whose s2 image lasts fewer than DB_CYCLES cycles never reaches the output.
- First edge with reset == 1 after reset: the sync chain starts loading. Outputs cannot change before the 2nd edge after reset is released.
- chg is high for exactly one cycle, coincident with the first cycle of the new clean value.
- DB_CYCLES == 1 gives the same latency as the bypass configuration (edge k+2).

## Configuration
- COND_DEBOUNCE_EN defined: debounce counters are present; behaviour is as above.
- COND_DEBOUNCE_EN undefined: counters and DB_CYCLES logic are compiled out; clean <= s2 on every edge.
  - Latency is fixed at edge k+2.
  - chg and evt_cnt still operate on clean-bit changes.
  - Glitches of one or more cycles on s2 pass through.

## Test plan
- Reset: hold reset=0 for 3 edges with all raw=1 -> i1..i4=0, chg=0, evt_cnt=0. Release reset -> i1..i4=1 at the 10th edge after release (default), chg pulses once, evt_cnt=1.
- Clean step: raw_i3 0->1 before edge k, held -> i3=1 and chg=1 at edge k+9 only; evt_cnt increments by 1.
- Glitch: raw_i1 high for 5 cycles, then low -> i1 stays 0, chg never asserts, evt_cnt unchanged. Repeat with 8 cycles held -> i1 rises at edge k+9.
- Simultaneous: raw_i1 and raw_i4 rise on the same cycle -> both outputs flip on the same edge, a single chg pulse, evt_cnt +1. Stagger raw_i4 by 2 cycles -> two chg pulses 2 cycles apart, evt_cnt +2.
- Reset mid-count: raw_i2 rises; assert reset=0 at edge k+5 for one edge, then release -> i2=0 through reset; i2 rises at the 10th edge after release, not earlier.
- Saturation and bypass: toggle raw_i1 300 times with full-length holds -> evt_cnt=255 and held. With COND_DEBOUNCE_EN undefined, a 1-cycle raw_i2 pulse -> i2 pulses 1 cycle at edge k+2 with chg.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the sequence-detector FSM: two-flop synchroniser, per-bit
// debounce (enabled by COND_DEBOUNCE_EN), change strobe and saturating event count.
module fsm_input_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_i1,
  input  logic       raw_i2,
  input  logic       raw_i3,
  input  logic       raw_i4,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       i4,
  output logic       chg,
  output logic [7:0] evt_cnt
);

  if (DB_CYCLES < 1 || DB_CYCLES > (1 << CNT_W) - 1) begin : g_param_check
    $error("DB_CYCLES must lie in 1..2**CNT_W-1");
  end

  logic [3:0] raw;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] clean;
  logic [3:0] clean_next;

  assign raw = {raw_i4, raw_i3, raw_i2, raw_i1};

`ifdef COND_DEBOUNCE_EN
  typedef enum logic {STABLE, PENDING} db_state_t;

  logic [3:0][CNT_W-1:0] cnt;
  logic [3:0][CNT_W-1:0] cnt_next;
  db_state_t [3:0]       state;

  // A bit is pending whenever the synchronised level disagrees with the clean one;
  // the flip happens on the edge whose increment would reach DB_CYCLES.
  always_comb begin
    clean_next = clean;
    cnt_next   = cnt;
    state      = {4{STABLE}};
    for (int b = 0; b < 4; b++) begin
      state[b] = (s2[b] != clean[b]) ? PENDING : STABLE;
      case (state[b])
        PENDING: begin
          if (cnt[b] == CNT_W'(DB_CYCLES - 1)) begin
            clean_next[b] = s2[b];
            cnt_next[b]   = '0;
          end else begin
            cnt_next[b] = cnt[b] + CNT_W'(1);
          end
        end
        default: cnt_next[b] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  always_comb begin
    clean_next = s2;
  end
`endif

  // chg and evt_cnt track any clean-bit change, whatever produced it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      clean   <= '0;
      chg     <= 1'b0;
      evt_cnt <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      clean <= clean_next;
      chg   <= (clean_next != clean);
      if ((clean_next != clean) && (evt_cnt != 8'hFF)) begin
        evt_cnt <= evt_cnt + 8'd1;
      end
    end
  end

  assign i1 = clean[0];
  assign i2 = clean[1];
  assign i3 = clean[2];
  assign i4 = clean[3];

endmodule
